// File: rtl/exp4_unidade_controle_jogo.sv
// Control unit for the play-by-play memory game: sequences counter/register/comparator per move.
// Optional timeout supervision is built when UC_TIMEOUT_EN is defined.
module exp4_unidade_controle_jogo #(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       fimC,
  input  logic       chavesIgualMemoria,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    ST_INICIAL     = 4'h0,
    ST_PREPARACAO  = 4'h1,
    ST_ESPERA      = 4'h2,
    ST_REGISTRA    = 4'h4,
    ST_COMPARACAO  = 4'h5,
    ST_PROXIMO     = 4'h6,
    ST_FIM_ACERTO  = 4'hA,
    ST_FIM_TIMEOUT = 4'hD,
    ST_FIM_ERRO    = 4'hE
  } estado_t;

  if (TIMEOUT_CICLOS < 2) begin : g_param_check
    $error("TIMEOUT_CICLOS must be at least 2");
  end

  estado_t    state_r;
  estado_t    next_s;
  logic       jogada_d_r;
  logic       jogada_pulso_s;
  logic       acertou_r;
  logic       errou_r;
  logic       timeout_r;

  assign jogada_pulso_s = jogada & ~jogada_d_r;

`ifdef UC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);
  logic [TW-1:0] timer_r;
  logic          timer_fim_s;

  assign timer_fim_s = (timer_r == TIMER_MAX);

  // Wait timer: runs only while waiting for a move, cleared everywhere else
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_r <= {TW{1'b0}};
    end else if ((state_r == ST_ESPERA) && !jogada_pulso_s) begin
      timer_r <= timer_r + TW'(1);
    end else begin
      timer_r <= {TW{1'b0}};
    end
  end
`endif

  // State register and move edge-detector history
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_INICIAL;
      jogada_d_r <= 1'b0;
    end else begin
      state_r    <= next_s;
      jogada_d_r <= jogada;
    end
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_INICIAL:    if (iniciar) next_s = ST_PREPARACAO; else next_s = ST_INICIAL;
      ST_PREPARACAO: next_s = ST_ESPERA;
      ST_ESPERA: begin
        // a move on the last timer cycle takes priority over the timeout
        if (jogada_pulso_s) next_s = ST_REGISTRA;
`ifdef UC_TIMEOUT_EN
        else if (timer_fim_s) next_s = ST_FIM_TIMEOUT;
`endif
        else next_s = ST_ESPERA;
      end
      ST_REGISTRA:   next_s = ST_COMPARACAO;
      ST_COMPARACAO: begin
        if (!chavesIgualMemoria) next_s = ST_FIM_ERRO;
        else if (fimC)           next_s = ST_FIM_ACERTO;
        else                     next_s = ST_PROXIMO;
      end
      ST_PROXIMO:    next_s = ST_ESPERA;
`ifdef UC_TIMEOUT_EN
      ST_FIM_TIMEOUT,
`endif
      ST_FIM_ACERTO,
      ST_FIM_ERRO:   if (iniciar) next_s = ST_PREPARACAO; else next_s = state_r;
      default:       next_s = ST_INICIAL;
    endcase
  end

  // Moore output decode from the state register
  always_comb begin
    zeraC     = 1'b0;
    zeraR     = 1'b0;
    contaC    = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    db_estado = 4'h0;
    case (state_r)
      ST_INICIAL:    db_estado = ST_INICIAL;
      ST_PREPARACAO: begin zeraC = 1'b1; zeraR = 1'b1; db_estado = ST_PREPARACAO; end
      ST_ESPERA:     db_estado = ST_ESPERA;
      ST_REGISTRA:   begin registraR = 1'b1; db_estado = ST_REGISTRA; end
      ST_COMPARACAO: db_estado = ST_COMPARACAO;
      ST_PROXIMO:    begin contaC = 1'b1; db_estado = ST_PROXIMO; end
`ifdef UC_TIMEOUT_EN
      ST_FIM_TIMEOUT: begin pronto = 1'b1; db_estado = ST_FIM_TIMEOUT; end
`endif
      ST_FIM_ACERTO: begin pronto = 1'b1; db_estado = ST_FIM_ACERTO; end
      ST_FIM_ERRO:   begin pronto = 1'b1; db_estado = ST_FIM_ERRO; end
      default:       db_estado = 4'h0;
    endcase
  end

  // Result flags: cleared on entering preparacao, set on entering their terminal state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acertou_r <= 1'b0;
      errou_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else if (next_s == ST_PREPARACAO) begin
      acertou_r <= 1'b0;
      errou_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      if ((next_s == ST_FIM_ACERTO) && (state_r != ST_FIM_ACERTO)) acertou_r <= 1'b1;
      if ((next_s == ST_FIM_ERRO) && (state_r != ST_FIM_ERRO))     errou_r   <= 1'b1;
`ifdef UC_TIMEOUT_EN
      if ((next_s == ST_FIM_TIMEOUT) && (state_r != ST_FIM_TIMEOUT)) begin
        errou_r   <= 1'b1;
        timeout_r <= 1'b1;
      end
`endif
    end
  end

  assign acertou = acertou_r;
  assign errou   = errou_r;
`ifdef UC_TIMEOUT_EN
  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_exp4_unidade_controle_jogo.sv
// Self-checking bench: behavioural datapath (counter, switch register, 16-entry memory)
// plus a game-level outcome model; randomized memories, move values and error positions.
module tb_exp4_unidade_controle_jogo;
  localparam int TMO = 20;

  logic clock = 1'b0;
  logic reset, iniciar, jogada, fimC, chavesIgualMemoria;
  logic zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  logic [3:0] mem [16];
  logic [3:0] addr = 4'd0;
  logic [3:0] sw_reg = 4'd0;
  logic [3:0] chaves = 4'd0;
  int n_zerac = 0, n_contac = 0, n_zerar = 0, n_registrar = 0;
  int checks = 0, failures = 0;

  always #5 clock = ~clock;

  exp4_unidade_controle_jogo #(.TIMEOUT_CICLOS(TMO)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .fimC(fimC),
    .chavesIgualMemoria(chavesIgualMemoria), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
    .registraR(registraR), .pronto(pronto), .acertou(acertou), .errou(errou),
    .timeout(timeout), .db_estado(db_estado)
  );

  assign fimC = (addr == 4'd15);
  assign chavesIgualMemoria = (sw_reg == mem[addr]);

  // Datapath model and pulse counters
  always @(posedge clock) begin
    if (zeraC) addr <= 4'd0; else if (contaC) addr <= addr + 4'd1;
    if (zeraR) sw_reg <= 4'd0; else if (registraR) sw_reg <= chaves;
    n_zerac     <= n_zerac + int'(zeraC);
    n_zerar     <= n_zerar + int'(zeraR);
    n_contac    <= n_contac + int'(contaC);
    n_registrar <= n_registrar + int'(registraR);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; iniciar = 1'b0; jogada = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    step(1);
    iniciar = 1'b0;
    checks++; if (db_estado !== 4'h1 || zeraC !== 1'b1 || zeraR !== 1'b1) begin failures++;
      $display("FAIL start_prep: db=%h zeraC=%b zeraR=%b exp db=1 zeraC=1 zeraR=1", db_estado, zeraC, zeraR); end
    checks++; if ({acertou, errou, timeout, pronto} !== 4'b0000) begin failures++;
      $display("FAIL start_flags_clear: acertou/errou/timeout/pronto=%b exp 0000", {acertou, errou, timeout, pronto}); end
    step(1);
    checks++; if (db_estado !== 4'h2) begin failures++;
      $display("FAIL start_wait: db=%h exp 2", db_estado); end
  endtask

  // Full game: err_idx<16 makes that move wrong, 16 means all moves correct
  task automatic play_game(input int err_idx);
    int moves, exp_conta, b_z, b_zr, b_c, b_r;
    bit exp_err;
    exp_err   = (err_idx < 16);
    moves     = exp_err ? err_idx + 1 : 16;
    exp_conta = exp_err ? err_idx : 15;
    fill_mem();
    b_z = n_zerac; b_zr = n_zerar; b_c = n_contac; b_r = n_registrar;
    start_game();
    for (int i = 0; i < moves; i++) begin
      step($urandom_range(0, 4));
      chaves = (i == err_idx) ? (mem[i] ^ 4'($urandom_range(1, 15))) : mem[i];
      jogada = 1'b1;
      step(1);
      checks++; if (db_estado !== 4'h4 || registraR !== 1'b1) begin failures++;
        $display("FAIL move_registra[%0d]: db=%h registraR=%b exp db=4 registraR=1", i, db_estado, registraR); end
      jogada = 1'b0;
      step(2);
      if (i == err_idx) begin
        checks++; if (db_estado !== 4'hE) begin failures++; $display("FAIL move_erro[%0d]: db=%h exp E", i, db_estado); end
      end else if (i == 15) begin
        checks++; if (db_estado !== 4'hA) begin failures++; $display("FAIL move_acerto[%0d]: db=%h exp A", i, db_estado); end
      end else begin
        checks++; if (db_estado !== 4'h6 || contaC !== 1'b1) begin failures++;
          $display("FAIL move_proximo[%0d]: db=%h contaC=%b exp db=6 contaC=1", i, db_estado, contaC); end
        step(1);
      end
    end
    checks++; if ({pronto, acertou, errou, timeout} !== {1'b1, !exp_err, exp_err, 1'b0}) begin failures++;
      $display("FAIL game_flags: pronto/acertou/errou/timeout=%b exp %b", {pronto, acertou, errou, timeout},
               {1'b1, !exp_err, exp_err, 1'b0}); end
    checks++; if ((n_contac - b_c) != exp_conta || (n_registrar - b_r) != moves) begin failures++;
      $display("FAIL game_pulses: contaC=%0d registraR=%0d exp %0d %0d", n_contac - b_c, n_registrar - b_r, exp_conta, moves); end
    checks++; if ((n_zerac - b_z) != 1 || (n_zerar - b_zr) != 1) begin failures++;
      $display("FAIL game_clears: zeraC=%0d zeraR=%0d exp 1 1", n_zerac - b_z, n_zerar - b_zr); end
    step(3);
    checks++; if (db_estado !== (exp_err ? 4'hE : 4'hA) || pronto !== 1'b1) begin failures++;
      $display("FAIL game_hold: db=%h pronto=%b exp %h 1", db_estado, pronto, exp_err ? 4'hE : 4'hA); end
  endtask

  task automatic test_reset();
    reset = 1'b0; iniciar = 1'b1; jogada = 1'b0; chaves = 4'd0;
    step(2);
    checks++; if ({zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado} !== 12'h000) begin failures++;
      $display("FAIL reset_outputs: %b exp all zero", {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado}); end
    iniciar = 1'b0;
    reset = 1'b1;
    step(2);
    checks++; if (db_estado !== 4'h0) begin failures++; $display("FAIL reset_idle: db=%h exp 0", db_estado); end
  endtask

  task automatic test_success();   play_game(16); endtask
  task automatic test_error();     play_game(2);  endtask

  task automatic test_random();
    for (int g = 0; g < 4; g++) play_game($urandom_range(0, 16));
  endtask

  task automatic test_hold();
    int b_r;
    fill_mem();
    start_game();
    b_r = n_registrar;
    chaves = mem[0];
    jogada = 1'b1;
    step(10);
    checks++; if ((n_registrar - b_r) != 1 || db_estado !== 4'h2) begin failures++;
      $display("FAIL hold_single: registraR=%0d db=%h exp 1 2", n_registrar - b_r, db_estado); end
    jogada = 1'b0;
    step(2);
    checks++; if (db_estado !== 4'h2 || (n_registrar - b_r) != 1) begin failures++;
      $display("FAIL hold_waits: db=%h registraR=%0d exp 2 1", db_estado, n_registrar - b_r); end
    do_reset();
  endtask

`ifdef UC_TIMEOUT_EN
  task automatic test_timeout();
    fill_mem();
    start_game();
    step(TMO - 1);
    checks++; if (db_estado !== 4'h2) begin failures++; $display("FAIL tmo_before: db=%h exp 2", db_estado); end
    step(1);
    checks++; if (db_estado !== 4'hD || {timeout, errou, pronto, acertou} !== 4'b1110) begin failures++;
      $display("FAIL tmo_fire: db=%h t/e/p/a=%b exp D 1110", db_estado, {timeout, errou, pronto, acertou}); end
    start_game();
    step(TMO - 1);
    checks++; if (db_estado !== 4'h2) begin failures++; $display("FAIL tmo_race_before: db=%h exp 2", db_estado); end
    chaves = mem[0];
    jogada = 1'b1;
    step(1);
    checks++; if (db_estado !== 4'h4 || timeout !== 1'b0) begin failures++;
      $display("FAIL tmo_race_move_wins: db=%h timeout=%b exp 4 0", db_estado, timeout); end
    jogada = 1'b0;
    step(3);
    do_reset();
  endtask
`endif

  task automatic test_reset_mid_game();
    int b_c;
    fill_mem();
    mem[1] = mem[0];
    start_game();
    chaves = mem[0];
    jogada = 1'b1;
    step(1);
    jogada = 1'b0;
    step(2);
    checks++; if (db_estado !== 4'h6 || contaC !== 1'b1) begin failures++;
      $display("FAIL abort_in_proximo: db=%h contaC=%b exp 6 1", db_estado, contaC); end
    b_c = n_contac;
    #1 reset = 1'b0;
    #1;
    checks++; if ({zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado} !== 12'h000) begin failures++;
      $display("FAIL abort_async: %b exp all zero", {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado}); end
    step(2);
    checks++; if (n_contac != b_c) begin failures++; $display("FAIL abort_no_conta: contaC=%0d exp 0", n_contac - b_c); end
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_back_to_back();
    play_game(16);
    play_game($urandom_range(0, 16));
`ifndef UC_TIMEOUT_EN
    start_game();
    step(1000);
    checks++; if (db_estado !== 4'h2 || timeout !== 1'b0 || pronto !== 1'b0) begin failures++;
      $display("FAIL idle_no_timeout: db=%h timeout=%b pronto=%b exp 2 0 0", db_estado, timeout, pronto); end
    do_reset();
`endif
  endtask

  initial begin
    test_reset();
    test_success();
    test_error();
    test_random();
    test_hold();
`ifdef UC_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_game();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
